// File: rtl/morse_pkg.sv
// Shared Morse types: character code, lookup symbol, FSM state and table sizes.
package morse_pkg;

    typedef logic [5:0] morse_char_t;

    // pattern is left-aligned: element i lives in bit 4-i, 1 = dash
    typedef struct packed {
        logic [4:0] pattern;
        logic [2:0] len;
        logic       valid;
    } morse_sym_t;

    localparam int MORSE_NUM_LETTERS = 26;
    localparam int MORSE_NUM_DIGITS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_CGAP
    } morse_tx_state_t;

    function automatic morse_sym_t mk_sym(input logic [4:0] pattern, input logic [2:0] len);
        morse_sym_t s;
        s.pattern = pattern;
        s.len     = len;
        s.valid   = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character -> Morse symbol lookup, shared by transmitter and decoder.
// MORSE_DIGITS_EN adds codes 26-35 (digits 0-9); otherwise those codes are invalid.
module morse_rom
    import morse_pkg::*;
(
    input  morse_char_t code,
    output morse_sym_t  sym
);

    // Table lookup; anything not listed comes back with valid = 0
    always_comb begin
        sym = '0;
        case (code)
            6'd0:  sym = mk_sym(5'b01000, 3'd2); // A .-
            6'd1:  sym = mk_sym(5'b10000, 3'd4); // B -...
            6'd2:  sym = mk_sym(5'b10100, 3'd4); // C -.-.
            6'd3:  sym = mk_sym(5'b10000, 3'd3); // D -..
            6'd4:  sym = mk_sym(5'b00000, 3'd1); // E .
            6'd5:  sym = mk_sym(5'b00100, 3'd4); // F ..-.
            6'd6:  sym = mk_sym(5'b11000, 3'd3); // G --.
            6'd7:  sym = mk_sym(5'b00000, 3'd4); // H ....
            6'd8:  sym = mk_sym(5'b00000, 3'd2); // I ..
            6'd9:  sym = mk_sym(5'b01110, 3'd4); // J .---
            6'd10: sym = mk_sym(5'b10100, 3'd3); // K -.-
            6'd11: sym = mk_sym(5'b01000, 3'd4); // L .-..
            6'd12: sym = mk_sym(5'b11000, 3'd2); // M --
            6'd13: sym = mk_sym(5'b10000, 3'd2); // N -.
            6'd14: sym = mk_sym(5'b11100, 3'd3); // O ---
            6'd15: sym = mk_sym(5'b01100, 3'd4); // P .--.
            6'd16: sym = mk_sym(5'b11010, 3'd4); // Q --.-
            6'd17: sym = mk_sym(5'b01000, 3'd3); // R .-.
            6'd18: sym = mk_sym(5'b00000, 3'd3); // S ...
            6'd19: sym = mk_sym(5'b10000, 3'd1); // T -
            6'd20: sym = mk_sym(5'b00100, 3'd3); // U ..-
            6'd21: sym = mk_sym(5'b00010, 3'd4); // V ...-
            6'd22: sym = mk_sym(5'b01100, 3'd3); // W .--
            6'd23: sym = mk_sym(5'b10010, 3'd4); // X -..-
            6'd24: sym = mk_sym(5'b10110, 3'd4); // Y -.--
            6'd25: sym = mk_sym(5'b11000, 3'd4); // Z --..
`ifdef MORSE_DIGITS_EN
            6'd26: sym = mk_sym(5'b11111, 3'd5); // 0
            6'd27: sym = mk_sym(5'b01111, 3'd5); // 1
            6'd28: sym = mk_sym(5'b00111, 3'd5); // 2
            6'd29: sym = mk_sym(5'b00011, 3'd5); // 3
            6'd30: sym = mk_sym(5'b00001, 3'd5); // 4
            6'd31: sym = mk_sym(5'b00000, 3'd5); // 5
            6'd32: sym = mk_sym(5'b10000, 3'd5); // 6
            6'd33: sym = mk_sym(5'b11000, 3'd5); // 7
            6'd34: sym = mk_sym(5'b11100, 3'd5); // 8
            6'd35: sym = mk_sym(5'b11110, 3'd5); // 9
`endif
            default: sym = '0;
        endcase
    end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: turns one character code into timed key-down/key-up intervals.
// Build option MORSE_DIGITS_EN (handled in morse_rom) enables digit codes 26-35.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned DOT_TICKS      = 3,
    parameter int unsigned DASH_TICKS     = 9,
    parameter int unsigned GAP_TICKS      = 3,
    parameter int unsigned CHAR_GAP_TICKS = 9
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] letter,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned MAX_A = (DOT_TICKS > DASH_TICKS) ? DOT_TICKS : DASH_TICKS;
    localparam int unsigned MAX_B = (GAP_TICKS > CHAR_GAP_TICKS) ? GAP_TICKS : CHAR_GAP_TICKS;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int          CNT_W = $clog2(MAX_T) + 1;

    localparam logic [CNT_W-1:0] DOT_C  = CNT_W'(DOT_TICKS);
    localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] CGAP_C = CNT_W'(CHAR_GAP_TICKS);

    morse_tx_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       pattern_q, pattern_d;
    logic [2:0]       len_q, len_d;
    logic             key_out_q, key_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    morse_sym_t sym;
    logic       expire;
    logic [2:0] idx_nx;
    logic       next_dash;

    morse_rom u_rom (
        .code (letter),
        .sym  (sym)
    );

    assign expire    = (cnt_q == CNT_W'(1));
    assign idx_nx    = idx_q + 3'd1;
    assign next_dash = pattern_q[3'd4 - idx_nx];

    // State, counter, latched symbol and registered outputs; reset clears everything
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            key_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            key_out_q <= key_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state: walk elements mark/space, then the trailing character gap
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start && sym.valid) begin
                    pattern_d = sym.pattern;
                    len_d     = sym.len;
                    idx_d     = 3'd0;
                    cnt_d     = sym.pattern[4] ? DASH_C : DOT_C;
                    state_d   = ST_MARK;
                end
            end
            ST_MARK: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_nx < len_q) begin
                    cnt_d   = GAP_C;
                    state_d = ST_SPACE;
                end else begin
                    cnt_d   = CGAP_C;
                    state_d = ST_CGAP;
                end
            end
            ST_SPACE: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    idx_d   = idx_nx;
                    cnt_d   = next_dash ? DASH_C : DOT_C;
                    state_d = ST_MARK;
                end
            end
            ST_CGAP: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state
    always_comb begin
        key_out_d = (state_d == ST_MARK);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_CGAP) && expire;
        err_d     = (state_q == ST_IDLE) && start && !sym.valid;
    end

    assign key_out = key_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder: directed cases plus random codes against a
// dot/dash string model of the Morse alphabet.
module tb_morse_encoder;

    localparam int DOT  = 3;
    localparam int DASH = 9;
    localparam int GAP  = 3;
    localparam int CGAP = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] letter;
    logic       key_out, busy, done, err;

    int compared   = 0;
    int mismatched = 0;

    bit wave[$];

    string tbl[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    always #5 clk = ~clk;

    morse_encoder #(
        .DOT_TICKS      (DOT),
        .DASH_TICKS     (DASH),
        .GAP_TICKS      (GAP),
        .CHAR_GAP_TICKS (CGAP)
    ) dut (
        .Clock   (clk),
        .reset   (reset),
        .start   (start),
        .letter  (letter),
        .key_out (key_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Dot/dash string for a code; empty string means the code is invalid
    function automatic string code_str(input int c);
        string s = "";
        if (c >= 0 && c < 26) s = tbl[c];
`ifdef MORSE_DIGITS_EN
        if (c >= 26 && c < 36) begin
            int d = c - 26;
            for (int k = 0; k < 5; k++) begin
                if (d <= 5) s = {s, (k < d) ? "." : "-"};
                else        s = {s, (k < d - 5) ? "-" : "."};
            end
        end
`endif
        return s;
    endfunction

    // Expected key level per cycle, from the cycle after start up to the done cycle
    task automatic build_wave(input string s);
        wave.delete();
        for (int i = 0; i < s.len(); i++) begin
            byte ch = s[i];
            int  m  = (ch == "-") ? DASH : DOT;
            int  g  = (i == s.len() - 1) ? CGAP : GAP;
            for (int t = 0; t < m; t++) wave.push_back(1'b1);
            for (int t = 0; t < g; t++) wave.push_back(1'b0);
        end
    endtask

    // Send one code and check every cycle; optional stray start at cycle pulse_at,
    // optional chained start on the done cycle, optional start already raised
    task automatic send(input int c, input int pulse_at, input bit chain,
                        input int next_c, input bit pre);
        string s = code_str(c);
        if (!pre) begin
            @(negedge clk);
            start  = 1'b1;
            letter = 6'(c);
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        letter = 6'($urandom_range(0, 63));
        if (s.len() == 0) begin
            @(negedge clk);
            chk($sformatf("err_pulse c%0d", c), err, 1'b1);
            chk($sformatf("err_busy c%0d", c), busy, 1'b0);
            chk($sformatf("err_key c%0d", c), key_out, 1'b0);
            @(negedge clk);
            chk($sformatf("err_clear c%0d", c), err, 1'b0);
            chk($sformatf("err_nodone c%0d", c), done, 1'b0);
            return;
        end
        build_wave(s);
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            if (i == pulse_at + 1) start = 1'b0;
            chk($sformatf("key c%0d cyc%0d", c, i + 1), key_out, wave[i]);
            chk($sformatf("busy c%0d cyc%0d", c, i + 1), busy, 1'b1);
            chk($sformatf("done_early c%0d cyc%0d", c, i + 1), done, 1'b0);
            chk($sformatf("err_valid c%0d cyc%0d", c, i + 1), err, 1'b0);
            if (i == pulse_at) begin
                start  = 1'b1;
                letter = 6'($urandom_range(0, 25));
            end
        end
        @(negedge clk);
        chk($sformatf("done c%0d", c), done, 1'b1);
        chk($sformatf("busy_end c%0d", c), busy, 1'b0);
        chk($sformatf("key_end c%0d", c), key_out, 1'b0);
        if (chain) begin
            start  = 1'b1;
            letter = 6'(next_c);
        end else begin
            @(negedge clk);
            chk($sformatf("done_one c%0d", c), done, 1'b0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        letter = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_key", key_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;

        // A, E, code 26 (invalid or digit 0 depending on build)
        send(0, -1, 1'b0, 0, 1'b0);
        send(4, -1, 1'b0, 0, 1'b0);
        send(26, -1, 1'b0, 0, 1'b0);

        // Stray start during busy is ignored; start on done is accepted
        send(0, 5, 1'b0, 0, 1'b0);
        send(0, -1, 1'b1, 4, 1'b0);
        send(4, -1, 1'b0, 0, 1'b1);

        // Reset in cycle 10 during the A dash
        @(negedge clk);
        start  = 1'b1;
        letter = 6'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_key_before", key_out, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_key", key_out, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet_done %0d", i), done, 1'b0);
            chk($sformatf("rst_quiet_key %0d", i), key_out, 1'b0);
        end
        send(4, -1, 1'b0, 0, 1'b0);

        // Whole alphabet
        for (int c = 0; c < 26; c++) send(c, -1, 1'b0, 0, 1'b0);

        // Random codes across the full 6-bit range, some with a stray start
        repeat (30) begin
            int c = int'($urandom_range(0, 63));
            int p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            send(c, p, 1'b0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
